// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router constants, header field layout and reader state type
package router_pkg;

  localparam int DATA_W      = 8;
  localparam int LEN_W       = DATA_W - 2;

  // header byte is {len, addr}
  localparam int ADDR_LSB    = 0;
  localparam int LEN_LSB     = 2;

  // flush timer of the router, shared with the synchronizer
  localparam int TIMEOUT_CYC = 30;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2
  } rd_state_t;

endpackage

// File: rtl/router_parity_acc.sv
// rtl/router_parity_acc.sv - running XOR of header and payload bytes with mismatch output
module router_parity_acc #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clr,
  input  logic              load,
  input  logic              accum,
  input  logic [DATA_W-1:0] din,
  output logic              err
);

  logic [DATA_W-1:0] acc;

  // Header starts a fresh sum, payload bytes fold in, flush clears
  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      acc <= '0;
    end else if (load) begin
      acc <= din;
    end else if (accum) begin
      acc <= acc ^ din;
    end
  end

  // Presented parity byte disagrees with the running sum
  assign err = (acc ^ din) != '0;

endmodule

// File: rtl/router_dest_reader.sv
// rtl/router_dest_reader.sv - port FIFO drain, packet parse and client byte stream; ROUTER_DEST_PARITY_CHK_EN enables parity checking
module router_dest_reader #(
  parameter int DATA_W    = 8,
  parameter int LEN_W     = 6,
  parameter int PKT_CNT_W = 16,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 vld_out,
  input  logic                 soft_reset,
  input  logic [DATA_W-1:0]    data_out,
  input  logic                 sink_stall,
  output logic                 read_enb,
  output logic                 byte_valid,
  output logic [DATA_W-1:0]    byte_data,
  output logic                 byte_sop,
  output logic                 byte_eop,
  output logic                 pkt_done,
  output logic                 parity_err,
  output logic                 pkt_abort,
  output logic [PKT_CNT_W-1:0] pkt_cnt,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  import router_pkg::*;

  // remaining counts cover payload plus the parity byte, so one bit wider than len
  localparam int REM_W = LEN_W + 1;

  rd_state_t        state;
  logic             rd_pend;
  logic [REM_W-1:0] req_rem;
  logic [REM_W-1:0] rcv_rem;
  logic [LEN_W-1:0] hdr_len;
  logic             last_arr;
  logic             par_err;

  assign hdr_len  = data_out[DATA_W-1:LEN_LSB];
  assign last_arr = rd_pend && (state == BODY) && (rcv_rem == REM_W'(1));

`ifdef ROUTER_DEST_PARITY_CHK_EN
  logic acc_clr;
  logic acc_load;
  logic acc_accum;

  assign acc_clr   = soft_reset;
  assign acc_load  = !soft_reset && rd_pend && (state == HDR);
  assign acc_accum = !soft_reset && rd_pend && (state == BODY) && !last_arr;

  router_parity_acc #(
    .DATA_W (DATA_W)
  ) u_parity_acc (
    .clk    (clk),
    .resetn (resetn),
    .clr    (acc_clr),
    .load   (acc_load),
    .accum  (acc_accum),
    .din    (data_out),
    .err    (par_err)
  );
`else
  assign par_err = 1'b0;
`endif

  // FIFO pop is combinational so the FIFO presents data the following cycle
  always_comb begin
    read_enb = 1'b0;
    if (resetn && vld_out && !sink_stall && !soft_reset) begin
      case (state)
        IDLE:    read_enb = 1'b1;
        BODY:    read_enb = (req_rem != '0);
        default: read_enb = 1'b0;
      endcase
    end
  end

  // Packet FSM with registered client stream, abort pulse and counters
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      rd_pend    <= 1'b0;
      req_rem    <= '0;
      rcv_rem    <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_sop   <= 1'b0;
      byte_eop   <= 1'b0;
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      pkt_abort  <= 1'b0;
      pkt_cnt    <= '0;
      err_cnt    <= '0;
    end else begin
      byte_valid <= 1'b0;
      byte_sop   <= 1'b0;
      byte_eop   <= 1'b0;
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      pkt_abort  <= 1'b0;
      rd_pend    <= read_enb;
      if (soft_reset) begin
        // the FIFO is being flushed: drop any arriving byte, including a parity byte
        state     <= IDLE;
        req_rem   <= '0;
        rcv_rem   <= '0;
        pkt_abort <= (state != IDLE);
      end else begin
        case (state)
          IDLE: begin
            if (read_enb) begin
              state <= HDR;
            end
          end
          HDR: begin
            if (rd_pend) begin
              req_rem    <= REM_W'(hdr_len) + REM_W'(1);
              rcv_rem    <= REM_W'(hdr_len) + REM_W'(1);
              byte_valid <= 1'b1;
              byte_data  <= data_out;
              byte_sop   <= 1'b1;
              state      <= BODY;
            end
          end
          BODY: begin
            if (read_enb) begin
              req_rem <= req_rem - REM_W'(1);
            end
            if (rd_pend) begin
              rcv_rem    <= rcv_rem - REM_W'(1);
              byte_valid <= 1'b1;
              byte_data  <= data_out;
              if (last_arr) begin
                byte_eop   <= 1'b1;
                pkt_done   <= 1'b1;
                parity_err <= par_err;
                state      <= IDLE;
                if (par_err) begin
                  if (err_cnt != '1) begin
                    err_cnt <= err_cnt + ERR_CNT_W'(1);
                  end
                end else begin
                  pkt_cnt <= pkt_cnt + PKT_CNT_W'(1);
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
